// File: rtl/up_datapath.sv
// rtl/up_datapath.sv - microcoded execution datapath
// Accumulator, 4-entry register file, registered zero flag and a handshaked output register.
module up_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ControlBus,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ack,
  output logic             Z,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDA = 3'b001,
    OP_LDR = 3'b010,
    OP_STR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_DEC = 3'b110,
    OP_CLR = 3'b111
  } op_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_regs [4];
  logic             r_z;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_overrun;

  op_t              w_op;
  logic [1:0]       w_sel;
  logic             w_zupd;
  logic             w_out;
  logic [WIDTH-1:0] w_reg_rd;
  logic [WIDTH-1:0] w_acc_next;

  assign w_op     = op_t'(ControlBus[6:4]);
  assign w_sel    = ControlBus[3:2];
  assign w_zupd   = ControlBus[1];
  assign w_out    = ControlBus[0];
  assign w_reg_rd = r_regs[w_sel];

  always_comb begin
    w_acc_next = r_acc;
    case (w_op)
      OP_LDA:  w_acc_next = data_in;
      OP_LDR:  w_acc_next = w_reg_rd;
      OP_ADD:  w_acc_next = r_acc + w_reg_rd;
      OP_SUB:  w_acc_next = r_acc - w_reg_rd;
      OP_DEC:  w_acc_next = r_acc - ONE;
      OP_CLR:  w_acc_next = '0;
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_z         <= 1'b1;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (w_op == OP_STR) r_regs[w_sel] <= r_acc;
      if (w_zupd) r_z <= (w_acc_next == '0);
      // OUT captures the pre-op accumulator; a same-cycle ack frees the slot for it
      if (w_out) begin
        if (!r_out_valid || out_ack) begin
          r_data_out  <= r_acc;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (out_ack && r_out_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign Z         = r_z;
  assign acc       = r_acc;
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_up_datapath.sv
// tb/tb_up_datapath.sv - self-checking bench for up_datapath
// Directed scenarios plus randomized words against an arithmetic reference model.
module tb_up_datapath;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic [6:0]   ControlBus;
  logic [W-1:0] data_in;
  logic         out_ack;
  logic         Z;
  logic [W-1:0] acc;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  int m_acc, m_z, m_dout, m_valid, m_ovr;
  int m_r [4];

  up_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ControlBus(ControlBus), .data_in(data_in),
    .out_ack(out_ack), .Z(Z), .acc(acc), .data_out(data_out),
    .out_valid(out_valid), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input int op, input int sel, input int zupd, input int o);
    mk = {3'(op), 2'(sel), 1'(zupd), 1'(o)};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_z = 1; m_dout = 0; m_valid = 0; m_ovr = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic model_step(input logic [6:0] cw, input int din, input int ack);
    int op, sel, nxt;
    op  = int'(cw[6:4]);
    sel = int'(cw[3:2]);
    nxt = m_acc;
    case (op)
      1: nxt = din;
      2: nxt = m_r[sel];
      3: m_r[sel] = m_acc;
      4: nxt = (m_acc + m_r[sel]) % MOD;
      5: nxt = (m_acc - m_r[sel] + MOD) % MOD;
      6: nxt = (m_acc + MOD - 1) % MOD;
      7: nxt = 0;
      default: nxt = m_acc;
    endcase
    if (cw[1]) m_z = (nxt == 0) ? 1 : 0;
    if (cw[0]) begin
      if (m_valid == 0 || ack != 0) begin m_dout = m_acc; m_valid = 1; end
      else m_ovr = 1;
    end else if (ack != 0 && m_valid != 0) begin
      m_valid = 0;
    end
    m_acc = nxt;
  endtask

  task automatic apply(input logic [6:0] cw, input int din, input int ack);
    @(negedge clk);
    ControlBus = cw;
    data_in    = W'(din);
    out_ack    = 1'(ack);
    model_step(cw, din, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ControlBus = '0; out_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ControlBus = '0; data_in = '0; out_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({Z, out_valid, overrun, acc, data_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_vals got Z=%b v=%b ovr=%b acc=%h dout=%h want 1 0 0 00 00",
               Z, out_valid, overrun, acc, data_out);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 1, 0), 8'h05, 0);
    checks++;
    if (acc !== 8'h05 || Z !== 1'b0) begin
      errors++;
      $display("FAIL first_lda got acc=%h Z=%b want 05 0", acc, Z);
    end
  endtask

  task automatic test_arith();
    apply(mk(1, 0, 0, 0), 8'h05, 0);
    apply(mk(3, 2, 0, 0), 0, 0);
    for (int k = 1; k <= 5; k++) begin
      apply(mk(6, 0, 1, 0), 0, 0);
      checks++;
      if (acc !== W'(5 - k) || Z !== ((k == 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL dec_%0d got acc=%h Z=%b want %h %b", k, acc, Z, W'(5 - k), (k == 5));
      end
    end
    apply(mk(2, 2, 0, 0), 0, 0);
    checks++;
    if (acc !== 8'h05) begin
      errors++;
      $display("FAIL ldr_r2 got acc=%h want 05", acc);
    end
  endtask

  task automatic test_wrap();
    apply(mk(7, 0, 0, 0), 0, 0);
    apply(mk(6, 0, 0, 0), 0, 0);
    checks++;
    if (acc !== 8'hFF) begin
      errors++;
      $display("FAIL dec_wrap got acc=%h want ff", acc);
    end
    apply(mk(1, 0, 0, 0), 8'hFF, 0);
    apply(mk(3, 1, 0, 0), 0, 0);
    apply(mk(1, 0, 0, 0), 8'h01, 0);
    apply(mk(4, 1, 1, 0), 0, 0);
    checks++;
    if (acc !== 8'h00 || Z !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap got acc=%h Z=%b want 00 1", acc, Z);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    apply(mk(1, 0, 0, 0), 8'h3C, 0);
    apply(mk(0, 0, 0, 1), 0, 0);
    checks++;
    if (data_out !== 8'h3C || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL out_load got dout=%h v=%b ovr=%b want 3c 1 0", data_out, out_valid, overrun);
    end
    apply(mk(1, 0, 0, 0), 8'h11, 0);
    apply(mk(0, 0, 0, 1), 0, 0);
    checks++;
    if (data_out !== 8'h3C || out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL out_drop got dout=%h v=%b ovr=%b want 3c 1 1", data_out, out_valid, overrun);
    end
    apply(mk(0, 0, 0, 0), 0, 1);
    checks++;
    if (data_out !== 8'h3C || out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ack_only got dout=%h v=%b ovr=%b want 3c 0 1", data_out, out_valid, overrun);
    end
    apply(mk(0, 0, 0, 0), 0, 1);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL ack_idle got v=%b dout=%h want 0 3c", out_valid, data_out);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(mk(1, 0, 0, 0), 8'h10, 0);
    apply(mk(0, 0, 0, 1), 0, 0);
    apply(mk(1, 0, 0, 0), 8'h22, 0);
    apply(mk(0, 0, 0, 1), 0, 1);
    checks++;
    if (data_out !== 8'h22 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL out_and_ack got dout=%h v=%b ovr=%b want 22 1 0", data_out, out_valid, overrun);
    end
  endtask

  task automatic test_async_reset();
    apply(mk(1, 0, 0, 0), 8'h5A, 0);
    apply(mk(3, 3, 0, 1), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Z, out_valid, overrun, acc, data_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got Z=%b v=%b ovr=%b acc=%h dout=%h want 1 0 0 00 00",
               Z, out_valid, overrun, acc, data_out);
    end
    model_reset();
    rst_n = 1'b1;
    apply(mk(1, 0, 1, 0), 8'h77, 0);
    checks++;
    if (acc !== 8'h77 || Z !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_word got acc=%h Z=%b want 77 0", acc, Z);
    end
    apply(mk(2, 3, 1, 0), 0, 0);
    checks++;
    if (acc !== 8'h00 || Z !== 1'b1) begin
      errors++;
      $display("FAIL regs_cleared got acc=%h Z=%b want 00 1", acc, Z);
    end
  endtask

  task automatic test_random();
    logic [6:0] cw;
    int din, ack, bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      cw  = 7'($urandom);
      din = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
      ack = ($urandom_range(0, 2) == 0) ? 1 : 0;
      apply(cw, din, ack);
      checks++;
      if ({acc, Z, data_out, out_valid, overrun} !==
          {W'(m_acc), 1'(m_z), W'(m_dout), 1'(m_valid), 1'(m_ovr)}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d cw=%b got acc=%h Z=%b dout=%h v=%b ovr=%b want %h %0d %h %0d %0d",
                   n, cw, acc, Z, data_out, out_valid, overrun, W'(m_acc), m_z, W'(m_dout), m_valid, m_ovr);
        bad++;
      end
      if (n % 97 == 96) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_wrap();
    test_handshake();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_datapath.md
# up_datapath

- Execution datapath that consumes the 7-bit microcontrol word issued each clock by the microprogram sequencer.
- Contains an accumulator, a four-entry register file and a registered zero flag `Z`; `Z` is returned to the sequencer for conditional branching.
- Presents results on an output holding register with a valid/acknowledge handshake.

## Interface

Parameters:
- `WIDTH`, default 8: datapath width of the accumulator, registers, `data_in` and `data_out`.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ControlBus`, input, 7: microcontrol word, sampled every rising edge.
- `data_in`, input, WIDTH: external operand for LDA.
- `out_ack`, input, 1: consumer accepts `data_out`.
- `Z`, output, 1: registered zero flag, to the sequencer.
- `acc`, output, WIDTH: current accumulator value (observability).
- `data_out`, output, WIDTH: output holding register.
- `out_valid`, output, 1: `data_out` holds unconsumed data.
- `overrun`, output, 1: sticky flag set when an OUT is dropped.

## Operation

Control word fields:
- `ControlBus[6:4]`: op.
- `[3:2]`: sel, selects R0..R3.
- `[1]`: zupd.
- `[0]`: OUT.

Ops, where R = R[sel]:
- 000 NOP: no change.
- 001 LDA: ACC <= data_in.
- 010 LDR: ACC <= R.
- 011 STR: R <= ACC.
- 100 ADD: ACC <= ACC + R.
- 101 SUB: ACC <= ACC − R.
- 110 DEC: ACC <= ACC − 1.
- 111 CLR: ACC <= 0.

Arithmetic:
- All arithmetic is modulo 2^WIDTH.
- Carry and borrow are discarded.
- There is no overflow flag.

Z flag:
- zupd=1: Z <= (new ACC == 0).
- For NOP and STR the new ACC equals the current ACC.
- zupd=0: Z holds its value.

OUT behaviour:
- Captures the ACC value present before this cycle's op, i.e. the current `acc` output.
- If `out_valid`=0, or `out_ack`=1 this cycle: data_out <= that value and out_valid <= 1.
- If `out_valid`=1 and `out_ack`=0: `data_out` is unchanged, the value is dropped and `overrun` <= 1.

Handshake:
- `out_ack` with `out_valid`=1 and no OUT: out_valid <= 0 next edge; `data_out` holds its last value.
- `out_ack` while `out_valid`=0 is ignored.
- OUT and `out_ack` in the same cycle with `out_valid`=1: old data is consumed, new data is loaded, `out_valid` stays 1, no overrun.

Other rules:
- `overrun` is sticky; only reset clears it.
- Every 7-bit pattern is defined by the tables above; there are no illegal encodings.
- STR with any op field combination cannot also write ACC; ops are mutually exclusive by encoding.

## Timing

Reset values (immediately on `rst_n` low, independent of `clk`):
- ACC=0, R0..R3=0.
- Z=1, consistent with ACC=0.
- data_out=0, out_valid=0, overrun=0.

Reset release:
- Deassertion is synchronous to the design: the first operation executes on the first rising edge with `rst_n`=1.
- Reset asserted mid-sequence discards all in-flight state, including a pending unacknowledged `data_out`.

Latency:
- 1 cycle from `ControlBus` sample to updated ACC, R, Z, `data_out` and `out_valid`.
- The sequencer samples `Z` at the same edge that presents the next word. A conditional branch therefore sees the Z produced by the word issued two edges earlier.
- Microcode must place one word between a zupd op and the branch that tests it.

Register file:
- STR followed by LDR of the same register on the next cycle reads the stored value.
- Writes are visible one edge later; no bypass is required because ops are sequential.

## Test plan

1. Reset, then LDA with data_in=0x05 and zupd=1.
   - Next cycle: acc=0x05, Z=0.
   - During reset: Z=1, out_valid=0.
2. Arithmetic sequence:
   - LDA 0x05; STR sel=2; DEC ×5, each with zupd=1.
   - Z=0 after DEC 1–4; acc=0x00 and Z=1 after DEC 5.
   - LDR sel=2 then gives acc=0x05.
3. Wrap-around:
   - CLR then DEC: acc=0xFF.
   - LDA 0xFF, STR R1, LDA 0x01, ADD R1 with zupd: acc=0x00, Z=1.
4. Handshake:
   - ACC=0x3C, OUT: data_out=0x3C, out_valid=1.
   - Hold out_ack=0, ACC=0x11, OUT: data_out stays 0x3C, overrun=1.
   - out_ack=1 alone: out_valid=0 next cycle; overrun remains 1.
5. Simultaneous events: out_valid=1 with ACC=0x22; OUT and out_ack in the same cycle give data_out=0x22, out_valid=1, overrun=0.
6. Asynchronous reset mid-run:
   - Assert rst_n=0 between edges with out_valid=1 and ACC≠0.
   - All outputs take reset values without waiting for a clock edge.
   - After release, the first edge executes the presented word.
